// File: rtl/controle_ula_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : controle_ula_multiciclo
// Description : Multicycle control FSM for the RV64I datapath. Fetches,
//               decodes and sequences each instruction. It drives the ULA
//               controls and resolves branches from the ULA compare flags.
//               It also handshakes with instruction and data memory and
//               issues the PC, IR and register-file strobes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   1   rising-edge clock
//   reset               in   1   synchronous, active-high
//   instr               in   32  instruction word, valid with imem_ack
//   imem_req / imem_ack          instruction fetch handshake
//   dmem_req / dmem_ack          data access handshake
//   dmem_we             out  1   1 = store (sd), 0 = load (ld)
//   flag_igual          in   1   ULA dina == dinb
//   flag_menor          in   1   ULA signed dina < dinb
//   flag_maior_igual_u  in   1   ULA unsigned dina >= dinb
//   soma_ou_subtrai     out  2   0 none, 1 add, 2 subtract
//   usa_imm             out  1   ULA operand B = immediate
//   ir_load             out  1   load IR (fetch accepted)
//   pc_load             out  1   update PC
//   pc_sel              out  1   0 PC+4, 1 PC+imm
//   reg_we              out  1   register-file write enable
//   wb_sel              out  2   0 ULA dout, 1 dmem data, 2 PC+4
//   erro                out  1   sticky illegal-instruction / timeout flag
//   estado              out  3   current state code
// ============================================================================
module controle_ula_multiciclo #(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        flag_igual,
  input  logic        flag_menor,
  input  logic        flag_maior_igual_u,
  output logic [1:0]  soma_ou_subtrai,
  output logic        usa_imm,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        erro,
  output logic [2:0]  estado
);

  localparam int CNT_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);

  localparam logic [2:0] S_BUSCA      = 3'd0;
  localparam logic [2:0] S_DECODIFICA = 3'd1;
  localparam logic [2:0] S_EXECUTA    = 3'd2;
  localparam logic [2:0] S_MEMORIA    = 3'd3;
  localparam logic [2:0] S_ESCRITA    = 3'd4;
  localparam logic [2:0] S_ERRO       = 3'd7;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0]       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Field decode of the latched instruction
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_add, is_sub, is_addi, is_ld, is_sd, is_br, is_jal;
  logic       legal;
  logic       br_taken;
  logic       unused_campos;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  // Register-source fields are consumed by the datapath, not by control.
  assign unused_campos = ^instr_q[24:15];

  assign is_add  = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub  = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_ld   = (opcode == OP_LOAD) && (funct3 == 3'b011);
  assign is_sd   = (opcode == OP_STORE) && (funct3 == 3'b011);
  // funct3 010 and 011 are not branch encodings.
  assign is_br   = (opcode == OP_BRANCH) && (funct3[2:1] != 2'b01);
  assign is_jal  = (opcode == OP_JAL);
  assign legal   = is_add | is_sub | is_addi | is_ld | is_sd | is_br | is_jal;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = flag_igual;
      3'b001:  br_taken = ~flag_igual;
      3'b100:  br_taken = flag_menor;
      3'b101:  br_taken = ~flag_menor;
      3'b110:  br_taken = ~flag_maior_igual_u;
      3'b111:  br_taken = flag_maior_igual_u;
      default: br_taken = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BUSCA;
      instr_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic, instruction latch and memory timeout counter.
  // The counter only runs while a request is outstanding; every other state
  // holds it at zero so entry into BUSCA/MEMORIA always starts from zero.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = '0;
    case (state_q)
      S_BUSCA: begin
        if (imem_ack) begin
          instr_d = instr;
          state_d = S_DECODIFICA;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERRO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODIFICA: begin
        state_d = legal ? S_EXECUTA : S_ERRO;
      end
      S_EXECUTA: begin
        if (is_br) begin
          state_d = S_BUSCA;
        end else if (is_ld || is_sd) begin
          state_d = S_MEMORIA;
        end else begin
          state_d = S_ESCRITA;
        end
      end
      S_MEMORIA: begin
        if (dmem_ack) begin
          state_d = is_sd ? S_BUSCA : S_ESCRITA;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERRO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ESCRITA: begin
        state_d = S_BUSCA;
      end
      S_ERRO: begin
        state_d = S_ERRO;
      end
      default: begin
        state_d = S_ERRO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. While reset is high the outputs look like an idle BUSCA so
  // that an aborted operation can never emit a late strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req        = 1'b0;
    ir_load         = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    soma_ou_subtrai = 2'd0;
    usa_imm         = 1'b0;
    pc_load         = 1'b0;
    pc_sel          = 1'b0;
    reg_we          = 1'b0;
    wb_sel          = 2'd0;
    erro            = 1'b0;
    estado          = 3'd0;
    if (reset) begin
      imem_req = 1'b1;
    end else begin
      estado = state_q;
      case (state_q)
        S_BUSCA: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        S_EXECUTA: begin
          if (is_add) begin
            soma_ou_subtrai = 2'd1;
          end else if (is_sub) begin
            soma_ou_subtrai = 2'd2;
          end else if (is_addi || is_ld || is_sd) begin
            soma_ou_subtrai = 2'd1;
            usa_imm         = 1'b1;
          end else if (is_br) begin
            soma_ou_subtrai = 2'd2;
            pc_load         = 1'b1;
            pc_sel          = br_taken;
          end
        end
        S_MEMORIA: begin
          soma_ou_subtrai = 2'd1;
          usa_imm         = 1'b1;
          dmem_req        = 1'b1;
          dmem_we         = is_sd;
          // A store completes here; the PC advances with the ack.
          pc_load         = is_sd & dmem_ack;
        end
        S_ESCRITA: begin
          reg_we  = (rd != 5'd0);
          pc_load = 1'b1;
          if (is_ld) begin
            wb_sel = 2'd1;
          end else if (is_jal) begin
            wb_sel = 2'd2;
            pc_sel = 1'b1;
          end
        end
        S_ERRO: begin
          erro = 1'b1;
        end
        default: begin
          erro = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_ula_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_ula_multiciclo
// Description : Self-checking bench for controle_ula_multiciclo. Each
//               instruction is expanded by a reference model into a per-cycle
//               list of inputs and expected outputs, which is then replayed
//               against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_ula_multiciclo;

  localparam int TO = 16;

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LD = 3,
                 K_SD = 4, K_BR = 5, K_JAL = 6, K_ILL = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        flag_igual = 1'b0, flag_menor = 1'b0, flag_maior_igual_u = 1'b0;
  logic        imem_req, dmem_req, dmem_we, usa_imm, ir_load, pc_load, pc_sel;
  logic        reg_we, erro;
  logic [1:0]  soma_ou_subtrai, wb_sel;
  logic [2:0]  estado;

  controle_ula_multiciclo #(.TIMEOUT_CICLOS(TO)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .flag_igual(flag_igual), .flag_menor(flag_menor),
    .flag_maior_igual_u(flag_maior_igual_u),
    .soma_ou_subtrai(soma_ou_subtrai), .usa_imm(usa_imm),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .erro(erro), .estado(estado)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  // One simulated cycle: inputs to apply and the output vector required.
  typedef struct packed {
    logic        rst;
    logic        iack;
    logic        dack;
    logic [2:0]  fl;     // {igual, menor, maior_igual_u}
    logic [31:0] w;
    logic [15:0] expv;
  } step_t;

  step_t trace[$];

  function automatic logic [15:0] mk(input logic [2:0] est, input logic ireq, input logic irl,
                                     input logic dreq, input logic dwe, input logic [1:0] sou,
                                     input logic imm, input logic pcl, input logic pcs,
                                     input logic rwe, input logic [1:0] wb, input logic er);
    return {est, ireq, irl, dreq, dwe, sou, imm, pcl, pcs, rwe, wb, er};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [2:0] rf();
    return 3'($urandom_range(7, 0));
  endfunction

  // Instruction class from the legal-instruction table.
  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
    if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
    if (op == 7'h03 && f3 == 3'd3) return K_LD;
    if (op == 7'h23 && f3 == 3'd3) return K_SD;
    if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) return K_BR;
    if (op == 7'h6F) return K_JAL;
    return K_ILL;
  endfunction

  // Branch decision from the mnemonic table (beq bne blt bge bltu bgeu).
  function automatic logic taken(input logic [2:0] f3, input logic [2:0] fl);
    logic eq, lt, geu;
    {eq, lt, geu} = fl;
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return !geu;
      3'd7: return geu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic rst, input logic iack, input logic dack,
                      input logic [2:0] fl, input logic [31:0] w, input logic [15:0] e);
    step_t s;
    s.rst = rst; s.iack = iack; s.dack = dack; s.fl = fl; s.w = w; s.expv = e;
    trace.push_back(s);
  endtask

  function automatic logic [15:0] rst_exp();
    return mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  // A few cycles parked in ERRO, then a one-cycle reset.
  task automatic erro_tail();
    for (int i = 0; i < 3; i++)
      push(0, rb(), rb(), rf(), $urandom, mk(3'd7, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1));
    push(1, 1, 1, rf(), $urandom, rst_exp());
  endtask

  // Reference model: expand one instruction into its cycle-by-cycle trace.
  task automatic build(input logic [31:0] w, input int iwait, input int dwait,
                       input logic [2:0] fl, input int rst_idx);
    int k;
    logic rdnz, sd, do_wb;
    logic [1:0] wb;
    k = classify(w);
    rdnz = (w[11:7] != 5'd0);
    sd = (k == K_SD);
    do_wb = 1'b0;
    trace.delete();
    for (int i = 0; i < iwait && i < TO; i++)
      push(0, 0, rb(), rf(), $urandom, mk(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0));
    if (iwait >= TO) begin
      erro_tail();
    end else begin
      push(0, 1, rb(), rf(), w, mk(3'd0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0));
      push(0, rb(), rb(), rf(), $urandom, mk(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0));
      if (k == K_ILL) begin
        erro_tail();
      end else begin
        case (k)
          K_ADD:  push(0, rb(), rb(), fl, $urandom, mk(3'd2, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 0));
          K_SUB:  push(0, rb(), rb(), fl, $urandom, mk(3'd2, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 2'd0, 0));
          K_BR:   push(0, rb(), rb(), fl, $urandom,
                       mk(3'd2, 0, 0, 0, 0, 2'd2, 0, 1, taken(w[14:12], fl), 0, 2'd0, 0));
          K_JAL:  push(0, rb(), rb(), fl, $urandom, mk(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0));
          default: push(0, rb(), rb(), fl, $urandom, mk(3'd2, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 2'd0, 0));
        endcase
        if (k == K_LD || k == K_SD) begin
          for (int i = 0; i < dwait && i < TO; i++)
            push(0, rb(), 0, rf(), $urandom, mk(3'd3, 0, 0, 1, sd, 2'd1, 1, 0, 0, 0, 2'd0, 0));
          if (dwait >= TO) begin
            erro_tail();
          end else begin
            push(0, rb(), 1, rf(), $urandom, mk(3'd3, 0, 0, 1, sd, 2'd1, 1, sd, 0, 0, 2'd0, 0));
            do_wb = !sd;
          end
        end else if (k != K_BR) begin
          do_wb = 1'b1;
        end
        if (do_wb) begin
          wb = (k == K_LD) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
          push(0, rb(), rb(), rf(), $urandom,
               mk(3'd4, 0, 0, 0, 0, 2'd0, 0, 1, (k == K_JAL), rdnz, wb, 0));
        end
      end
    end
    // Optional reset in the middle of the sequence: everything after it is dropped.
    if (rst_idx >= 0 && rst_idx < trace.size()) begin
      trace[rst_idx].rst  = 1'b1;
      trace[rst_idx].iack = 1'b1;
      trace[rst_idx].dack = 1'b1;
      trace[rst_idx].expv = rst_exp();
      while (trace.size() > rst_idx + 1) void'(trace.pop_back());
    end
  endtask

  task automatic play(input string name);
    logic [15:0] obs;
    foreach (trace[i]) begin
      @(posedge clk);
      #1;
      reset    = trace[i].rst;
      imem_ack = trace[i].iack;
      dmem_ack = trace[i].dack;
      {flag_igual, flag_menor, flag_maior_igual_u} = trace[i].fl;
      instr    = trace[i].w;
      @(negedge clk);
      obs = {estado, imem_req, ir_load, dmem_req, dmem_we, soma_ou_subtrai,
             usa_imm, pc_load, pc_sel, reg_we, wb_sel, erro};
      check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(trace[i].expv));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0] bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    w = $urandom;
    case ($urandom_range(7, 0))
      0: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      1: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      2: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      3: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      4: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      5: begin w[6:0] = 7'h63; w[14:12] = bf[$urandom_range(5, 0)]; end
      6: begin w[6:0] = 7'h6F; end
      default: ;
    endcase
    if ($urandom_range(3, 0) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    logic [2:0] bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    // Power-on reset.
    trace.delete();
    push(1, 1, 1, 3'd0, 32'd0, rst_exp());
    push(1, 0, 0, 3'd0, 32'd0, rst_exp());
    play("reset");

    // add x3,x1,x2 with immediate ack.
    build(32'h002081B3, 0, 0, rf(), -1);
    play("add");

    // All branch conditions against all flag combinations.
    foreach (bf[j]) begin
      for (int f = 0; f < 8; f++) begin
        build({7'd0, 5'd2, 5'd1, bf[j], 5'd8, 7'h63}, 0, 0, 3'(f), -1);
        play($sformatf("br_f3%0d_fl%0d", bf[j], f));
      end
    end

    // ld / sd with a 5-cycle data-memory wait.
    build(32'h0000B183, 0, 5, rf(), -1);
    play("ld_wait5");
    build(32'h0020B023, 0, 5, rf(), -1);
    play("sd_wait5");

    // Fetch timeout boundary: ack on the last permitted cycle, then never.
    build(32'h002081B3, TO - 1, 0, rf(), -1);
    play("fetch_ack_last");
    build(32'h002081B3, TO, 0, rf(), -1);
    play("fetch_timeout");

    // Data timeout boundary.
    build(32'h0000B183, 0, TO - 1, rf(), -1);
    play("ld_ack_last");
    build(32'h0000B183, 0, TO, rf(), -1);
    play("ld_timeout");

    // Illegal instruction.
    build(32'hFFFFFFFF, 0, 0, rf(), -1);
    play("illegal");

    // Reset in the first MEMORIA cycle of a store, with the ack present.
    build(32'h0020B023, 0, 0, rf(), 3);
    play("rst_in_mem");
    build(32'h002081B3, 0, 0, rf(), -1);
    play("after_rst");

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      int iw, dw, ri;
      iw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TO + 1, TO - 2)) : int'($urandom_range(3, 0));
      dw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TO + 1, TO - 2)) : int'($urandom_range(3, 0));
      ri = ($urandom_range(15, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
      build(rand_instr(), iw, dw, rf(), ri);
      play($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
